regfile_debug_ctrl: RTL and testbench
=====================================

// Module: regfile_debug_ctrl
// PURPOSE
//   UART-driven debug controller for the 32x32 register file. Parses byte
//   commands from the UART receiver and halts/resumes the core. Reads or
//   writes any register through the register file's debug port. Replies
//   over the UART transmitter.
//   Sits between the UART RX/TX blocks and the register file debug port.
//   Arbitration rule: debug writes are granted only while the core is halted.
// PARAMETERS
//   TIMEOUT_CYCLES  5_000_000  inter-byte timeout mid-command (100 ms @ 50 MHz)
//   HALT_SETTLE     4          cycles between core_halt rising and the 'H' ack
//   ACK_BYTE        8'h4B      'K', success reply
//   ERR_BYTE        8'h45      'E', error reply
// PORTS
//   clk_50M    in   1   system clock
//   rst        in   1   reset, synchronous, active-low
//   rx_data    in   8   received byte
//   rx_valid   in   1   one-cycle strobe; rx_data valid
//   tx_busy    in   1   transmitter busy
//   tx_data    out  8   byte to transmit
//   tx_start   out  1   one-cycle transmit strobe
//   core_halt  out  1   1 = core clock enable withheld
//   dbg_addr   out  5   register file debug address
//   dbg_wdata  out  32  register file debug write data
//   dbg_we     out  1   one-cycle debug write strobe
//   dbg_rdata  in   32  register file debug read data, combinational from dbg_addr
//   busy       out  1   1 whenever state != IDLE
// BEHAVIOUR
//   Reset (rst==0 at posedge clk_50M):
//     - all outputs 0, state IDLE, counters 0.
//     - core_halt is cleared, so a reset mid-command resumes the core.
//   Commands (first byte):
//     'H' 8'h48  set core_halt; wait HALT_SETTLE cycles; send ACK.
//     'G' 8'h47  clear core_halt; send ACK.
//     'R' 8'h52, addr  read register; send 4 bytes, MSB first.
//     'W' 8'h57, addr, d3, d2, d1, d0  write register; send ACK.
//     any other byte  send ERR.
//   Addr byte: bits[4:0] are the register index. If bits[7:5] != 0, send ERR
//     and drop any remaining bytes of the command.
//   States:
//     IDLE -> GET_ADDR on 'R'/'W'.
//     IDLE -> HALT_WAIT on 'H'.
//     IDLE -> LOAD_TX on 'G' or an unknown byte.
//     GET_ADDR -> READ ('R').
//     GET_ADDR -> GET_DATA ('W'); GET_DATA collects 4 bytes into a shift
//       register, MSB first.
//     GET_DATA -> EXEC.
//     READ: drive dbg_addr; on the next cycle latch dbg_rdata (1-cycle
//       latency); go to LOAD_TX with a byte count of 4.
//     EXEC: if core_halt==0 send ERR with no write. Otherwise pulse dbg_we
//       for 1 cycle (suppressed for addr 0, still ACKed); then LOAD_TX.
//     LOAD_TX: wait tx_busy==0; drive tx_data and pulse tx_start for
//       1 cycle; go to WAIT_TX.
//     WAIT_TX:
//       - ignore tx_busy for 1 cycle, then wait tx_busy==0;
//       - if bytes remain, return to LOAD_TX, else go to IDLE.
//   Timeout: in GET_ADDR/GET_DATA, a counter reloads on each rx_valid. When
//     it reaches TIMEOUT_CYCLES-1, go to IDLE silently; no write, no reply.
//   rx_valid outside IDLE/GET_ADDR/GET_DATA is dropped; no queueing.
//   'R' is legal while the core runs; the returned value may be stale by
//     one write.
//   'H' while already halted re-ACKs after HALT_SETTLE.
//   'G' while already running ACKs.
//   dbg_wdata/dbg_addr hold their last value outside EXEC/READ.
// TESTING
//   1. reset, then 'H' -> core_halt=1 at the cycle after the 'H' strobe;
//      tx_start with 8'h4B exactly HALT_SETTLE cycles later.
//   2. 'H', then 'W',05,DE,AD,BE,EF -> one dbg_we pulse, dbg_addr=5,
//      dbg_wdata=32'hDEADBEEF; reply 8'h4B.
//   3. 'R',09 with dbg_rdata=32'h00000004 -> tx bytes 00,00,00,04 in order;
//      each tx_start only when tx_busy==0.
//   4. 'G', then 'W',03,... -> no dbg_we; reply 8'h45.
//      'R',20 -> reply 8'h45, no read.
//   5. 'W',02,11 then silence for TIMEOUT_CYCLES -> return to IDLE, busy=0,
//      no tx; a following 'G' is ACKed normally.
//   6. rst low during WAIT_TX of a read reply -> all outputs 0, core_halt=0
//      next cycle; no further tx_start.

Source files
------------

// File: rtl/regfile_debug_ctrl.sv
// UART debug controller for the 32x32 register file.
// Parses byte commands from the UART receiver, halts and resumes the core,
// reads or writes registers through the debug port, and replies over the
// UART transmitter.
//
// state     | meaning
// IDLE      | waiting for a command byte
// GET_ADDR  | waiting for the address byte of 'R'/'W'
// GET_DATA  | collecting 4 write-data bytes, MSB first
// READ      | dbg_addr driven, capture dbg_rdata
// EXEC      | perform (or refuse) the debug write
// HALT_WAIT | core_halt raised, letting the core settle
// LOAD_TX   | hand the next reply byte to the transmitter
// WAIT_TX   | wait for the transmitter to finish the byte
module regfile_debug_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter int unsigned HALT_SETTLE    = 4,
  parameter logic [7:0]  ACK_BYTE       = 8'h4B,
  parameter logic [7:0]  ERR_BYTE       = 8'h45
) (
  input  logic        clk_50M,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        core_halt,
  output logic [4:0]  dbg_addr,
  output logic [31:0] dbg_wdata,
  output logic        dbg_we,
  input  logic [31:0] dbg_rdata,
  output logic        busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned SW = $clog2(HALT_SETTLE + 1);
  // Down-counters reach zero one cycle before the transition they trigger.
  localparam logic [TW-1:0] TMO_LOAD    = TW'(TIMEOUT_CYCLES - 2);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(HALT_SETTLE - 2);

  localparam logic [7:0] CMD_H = 8'h48;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_W = 8'h57;

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, READ, EXEC, HALT_WAIT, LOAD_TX, WAIT_TX
  } state_t;

  state_t        state;
  logic          is_write;
  logic          addr_err;
  logic [4:0]    addr_q;
  logic [31:0]   data_q;
  logic [1:0]    data_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [SW-1:0] settle_cnt;
  logic [31:0]   reply_q;
  logic [2:0]    bytes_left;
  logic          tx_skip;

  assign busy = (state != IDLE);

  // Command parser, debug-port sequencing and reply serializer.
  always_ff @(posedge clk_50M) begin
    if (!rst) begin
      state      <= IDLE;
      tx_data    <= 8'h00;
      tx_start   <= 1'b0;
      core_halt  <= 1'b0;
      dbg_addr   <= 5'd0;
      dbg_wdata  <= 32'd0;
      dbg_we     <= 1'b0;
      is_write   <= 1'b0;
      addr_err   <= 1'b0;
      addr_q     <= 5'd0;
      data_q     <= 32'd0;
      data_cnt   <= 2'd0;
      tmo_cnt    <= '0;
      settle_cnt <= '0;
      reply_q    <= 32'd0;
      bytes_left <= 3'd0;
      tx_skip    <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      dbg_we   <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid) begin
            case (rx_data)
              CMD_H: begin
                core_halt  <= 1'b1;
                settle_cnt <= SETTLE_LOAD;
                state      <= HALT_WAIT;
              end
              CMD_G: begin
                core_halt  <= 1'b0;
                reply_q    <= {ACK_BYTE, 24'h0};
                bytes_left <= 3'd1;
                state      <= LOAD_TX;
              end
              CMD_R, CMD_W: begin
                is_write <= (rx_data == CMD_W);
                tmo_cnt  <= TMO_LOAD;
                state    <= GET_ADDR;
              end
              default: begin
                reply_q    <= {ERR_BYTE, 24'h0};
                bytes_left <= 3'd1;
                state      <= LOAD_TX;
              end
            endcase
          end
        end
        GET_ADDR: begin
          if (rx_valid) begin
            tmo_cnt  <= TMO_LOAD;
            addr_q   <= rx_data[4:0];
            addr_err <= (rx_data[7:5] != 3'b000);
            if (is_write) begin
              // A bad write address still swallows its data bytes so they
              // are not parsed as new commands; the error is sent from EXEC.
              data_cnt <= 2'd0;
              state    <= GET_DATA;
            end else if (rx_data[7:5] != 3'b000) begin
              reply_q    <= {ERR_BYTE, 24'h0};
              bytes_left <= 3'd1;
              state      <= LOAD_TX;
            end else begin
              dbg_addr <= rx_data[4:0];
              state    <= READ;
            end
          end else if (tmo_cnt == '0) begin
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - TW'(1);
          end
        end
        GET_DATA: begin
          if (rx_valid) begin
            tmo_cnt  <= TMO_LOAD;
            data_q   <= {data_q[23:0], rx_data};
            data_cnt <= data_cnt + 2'd1;
            if (data_cnt == 2'd3) state <= EXEC;
          end else if (tmo_cnt == '0) begin
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - TW'(1);
          end
        end
        READ: begin
          reply_q    <= dbg_rdata;
          bytes_left <= 3'd4;
          state      <= LOAD_TX;
        end
        EXEC: begin
          if (core_halt && !addr_err) begin
            reply_q <= {ACK_BYTE, 24'h0};
            // Register 0 is hardwired; the write is dropped but acknowledged.
            if (addr_q != 5'd0) begin
              dbg_we    <= 1'b1;
              dbg_addr  <= addr_q;
              dbg_wdata <= data_q;
            end
          end else begin
            reply_q <= {ERR_BYTE, 24'h0};
          end
          bytes_left <= 3'd1;
          state      <= LOAD_TX;
        end
        HALT_WAIT: begin
          if (settle_cnt == '0) begin
            reply_q    <= {ACK_BYTE, 24'h0};
            bytes_left <= 3'd1;
            state      <= LOAD_TX;
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
        end
        LOAD_TX: begin
          if (!tx_busy) begin
            tx_data    <= reply_q[31:24];
            tx_start   <= 1'b1;
            reply_q    <= {reply_q[23:0], 8'h00};
            bytes_left <= bytes_left - 3'd1;
            tx_skip    <= 1'b1;
            state      <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          // The transmitter raises tx_busy a cycle after tx_start.
          if (tx_skip) begin
            tx_skip <= 1'b0;
          end else if (!tx_busy) begin
            state <= (bytes_left != 3'd0) ? LOAD_TX : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_debug_ctrl.sv
// Self-checking bench for regfile_debug_ctrl: directed scenarios plus a
// randomized command stream checked against a behavioural model.
module tb_regfile_debug_ctrl;

  localparam int TMO    = 40;
  localparam int SETTLE = 4;

  logic        clk_50M  = 1'b0;
  logic        rst      = 1'b0;
  logic [7:0]  rx_data  = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_busy  = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        core_halt;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_we;
  logic [31:0] dbg_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf [32];
  logic [31:0] m_regs [32];
  bit          m_halted;

  logic [7:0]  txq[$];
  logic [36:0] wrq[$];
  logic [7:0]  cmd_q[$];
  logic [7:0]  exp_reply[$];
  logic [36:0] exp_wr[$];
  int          busy_viol = 0;
  int          busy_left = 0;

  regfile_debug_ctrl #(.TIMEOUT_CYCLES(TMO), .HALT_SETTLE(SETTLE)) dut (
    .clk_50M(clk_50M), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_start(tx_start),
    .core_halt(core_halt), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_we(dbg_we), .dbg_rdata(dbg_rdata), .busy(busy)
  );

  always #10 clk_50M = ~clk_50M;

  assign dbg_rdata = rf[dbg_addr];

  // UART transmitter and register file stand-ins.
  always @(negedge clk_50M) begin
    if (tx_start) begin
      if (tx_busy) busy_viol++;
      txq.push_back(tx_data);
      tx_busy   = 1'b1;
      busy_left = int'($urandom_range(1, 6));
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) tx_busy = 1'b0;
    end
    if (dbg_we) begin
      wrq.push_back({dbg_addr, dbg_wdata});
      rf[dbg_addr] = dbg_wdata;
    end
  end

  task automatic tick();
    @(negedge clk_50M);
    #1;
  endtask

  task automatic clear_q();
    txq.delete(); wrq.delete(); cmd_q.delete(); exp_reply.delete(); exp_wr.delete();
  endtask

  task automatic send_cmd();
    foreach (cmd_q[i]) begin
      if (i != 0) repeat ($urandom_range(0, 3)) tick();
      tick();
      rx_data  = cmd_q[i];
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || tx_busy) && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (busy || tx_busy) begin
      errors++;
      $display("FAIL wait_idle: busy=%0b tx_busy=%0b after %0d cycles, required idle", busy, tx_busy, n);
    end
    tick(); tick();
  endtask

  function automatic bit eq8(input logic [7:0] a[$], input logic [7:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit eq37(input logic [36:0] a[$], input logic [36:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if ({tx_start, tx_data, core_halt, dbg_we} !== 11'd0) begin
      errors++;
      $display("FAIL reset_tx_ctl: start=%0b data=%h halt=%0b we=%0b, required all 0", tx_start, tx_data, core_halt, dbg_we);
    end
    checks++;
    if ({dbg_addr, dbg_wdata, busy} !== 38'd0) begin
      errors++;
      $display("FAIL reset_dbg: addr=%0d wdata=%h busy=%0b, required all 0", dbg_addr, dbg_wdata, busy);
    end
    rst = 1'b1;
    m_halted = 1'b0;
    tick();
  endtask

  task automatic test_halt_timing();
    int got = -1;
    logic [7:0] dat = 8'h00;
    clear_q();
    tick();
    rx_data = 8'h48; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    checks++;
    if (core_halt !== 1'b1) begin
      errors++;
      $display("FAIL halt_rise: core_halt=%0b one cycle after 'H', required 1", core_halt);
    end
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (tx_start === 1'b1 && got < 0) begin got = k; dat = tx_data; end
    end
    checks++;
    if (got != SETTLE || dat !== 8'h4B) begin
      errors++;
      $display("FAIL halt_ack: tx_start at +%0d byte %h, required +%0d byte 4b", got, dat, SETTLE);
    end
    wait_idle();
    m_halted = 1'b1;
  endtask

  task automatic test_write_halted();
    clear_q();
    cmd_q = '{8'h57, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_cmd();
    wait_idle();
    m_regs[5] = 32'hDEADBEEF;
    exp_wr = '{{5'd5, 32'hDEADBEEF}};
    exp_reply = '{8'h4B};
    checks++;
    if (!eq37(wrq, exp_wr)) begin
      errors++;
      $display("FAIL write_port: writes %p, required %p", wrq, exp_wr);
    end
    checks++;
    if (!eq8(txq, exp_reply)) begin
      errors++;
      $display("FAIL write_reply: bytes %p, required %p", txq, exp_reply);
    end
    checks++;
    if (dbg_addr !== 5'd5 || dbg_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_hold: addr=%0d wdata=%h, required 5 deadbeef", dbg_addr, dbg_wdata);
    end
    clear_q();
    cmd_q = '{8'h57, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};
    send_cmd();
    wait_idle();
    exp_reply = '{8'h4B};
    checks++;
    if (wrq.size() != 0 || !eq8(txq, exp_reply)) begin
      errors++;
      $display("FAIL write_r0: %0d writes, bytes %p, required 0 writes and %p", wrq.size(), txq, exp_reply);
    end
  endtask

  task automatic test_read();
    clear_q();
    busy_viol = 0;
    rf[9] = 32'h00000004;
    m_regs[9] = 32'h00000004;
    cmd_q = '{8'h52, 8'h09};
    send_cmd();
    wait_idle();
    exp_reply = '{8'h00, 8'h00, 8'h00, 8'h04};
    checks++;
    if (!eq8(txq, exp_reply)) begin
      errors++;
      $display("FAIL read_bytes: bytes %p, required %p", txq, exp_reply);
    end
    checks++;
    if (busy_viol != 0) begin
      errors++;
      $display("FAIL read_tx_busy: %0d tx_start while tx_busy, required 0", busy_viol);
    end
  endtask

  task automatic test_running_errors();
    clear_q();
    cmd_q = '{8'h47};
    send_cmd();
    wait_idle();
    m_halted = 1'b0;
    exp_reply = '{8'h4B};
    checks++;
    if (!eq8(txq, exp_reply) || core_halt !== 1'b0) begin
      errors++;
      $display("FAIL go_ack: bytes %p halt=%0b, required %p halt=0", txq, core_halt, exp_reply);
    end
    clear_q();
    cmd_q = '{8'h57, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_cmd();
    wait_idle();
    exp_reply = '{8'h45};
    checks++;
    if (wrq.size() != 0 || !eq8(txq, exp_reply)) begin
      errors++;
      $display("FAIL write_running: %0d writes, bytes %p, required 0 writes and %p", wrq.size(), txq, exp_reply);
    end
    clear_q();
    cmd_q = '{8'h52, 8'h20};
    send_cmd();
    wait_idle();
    exp_reply = '{8'h45};
    checks++;
    if (!eq8(txq, exp_reply)) begin
      errors++;
      $display("FAIL read_bad_addr: bytes %p, required %p", txq, exp_reply);
    end
  endtask

  task automatic test_timeout();
    clear_q();
    cmd_q = '{8'h57, 8'h02, 8'h11};
    send_cmd();
    repeat (TMO / 2) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: busy=%0b mid-command, required 1", busy);
    end
    repeat (TMO) tick();
    checks++;
    if (busy !== 1'b0 || txq.size() != 0 || wrq.size() != 0) begin
      errors++;
      $display("FAIL timeout: busy=%0b tx=%0d writes=%0d, required 0 0 0", busy, txq.size(), wrq.size());
    end
    clear_q();
    cmd_q = '{8'h47};
    send_cmd();
    wait_idle();
    m_halted = 1'b0;
    exp_reply = '{8'h4B};
    checks++;
    if (!eq8(txq, exp_reply)) begin
      errors++;
      $display("FAIL timeout_recover: bytes %p, required %p", txq, exp_reply);
    end
  endtask

  task automatic test_random();
    logic [7:0]  b;
    logic [4:0]  a;
    logic [31:0] d;
    int          kind;
    busy_viol = 0;
    for (int n = 0; n < 60; n++) begin
      clear_q();
      kind = int'($urandom_range(0, 7));
      a = 5'($urandom_range(0, 31));
      d = $urandom;
      case (kind)
        0: begin cmd_q = '{8'h48}; m_halted = 1'b1; exp_reply = '{8'h4B}; end
        1: begin cmd_q = '{8'h47}; m_halted = 1'b0; exp_reply = '{8'h4B}; end
        2: begin
          cmd_q = '{8'h52, {3'b000, a}};
          exp_reply = '{m_regs[a][31:24], m_regs[a][23:16], m_regs[a][15:8], m_regs[a][7:0]};
        end
        3: begin
          cmd_q = '{8'h52, {3'($urandom_range(1, 7)), a}};
          exp_reply = '{8'h45};
        end
        4, 5: begin
          cmd_q = '{8'h57, {3'b000, a}, d[31:24], d[23:16], d[15:8], d[7:0]};
          if (m_halted) begin
            exp_reply = '{8'h4B};
            if (a != 5'd0) begin m_regs[a] = d; exp_wr = '{{a, d}}; end
          end else begin
            exp_reply = '{8'h45};
          end
        end
        6: begin
          cmd_q = '{8'h57, {3'($urandom_range(1, 7)), a}, d[31:24], d[23:16], d[15:8], d[7:0]};
          exp_reply = '{8'h45};
        end
        default: begin
          b = 8'($urandom_range(0, 255));
          while (b == 8'h48 || b == 8'h47 || b == 8'h52 || b == 8'h57) b = 8'($urandom_range(0, 255));
          cmd_q = '{b};
          exp_reply = '{8'h45};
        end
      endcase
      send_cmd();
      wait_idle();
      checks++;
      if (!eq8(txq, exp_reply) || !eq37(wrq, exp_wr)) begin
        errors++;
        $display("FAIL random[%0d] kind %0d cmd %p: bytes %p writes %p, required %p %p", n, kind, cmd_q, txq, wrq, exp_reply, exp_wr);
      end
      checks++;
      if (core_halt !== m_halted) begin
        errors++;
        $display("FAIL random_halt[%0d]: core_halt=%0b, required %0b", n, core_halt, m_halted);
      end
    end
    checks++;
    if (busy_viol != 0) begin
      errors++;
      $display("FAIL random_tx_busy: %0d tx_start while tx_busy, required 0", busy_viol);
    end
  endtask

  task automatic test_reset_mid_read();
    clear_q();
    cmd_q = '{8'h48};
    send_cmd();
    wait_idle();
    clear_q();
    cmd_q = '{8'h52, 8'h07};
    send_cmd();
    for (int i = 0; i < 200 && txq.size() == 0; i++) tick();
    checks++;
    if (txq.size() != 1) begin
      errors++;
      $display("FAIL reset_mid_setup: %0d bytes sent, required 1 before reset", txq.size());
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({tx_start, tx_data, core_halt, dbg_we, dbg_addr, dbg_wdata, busy} !== 49'd0) begin
      errors++;
      $display("FAIL reset_mid_read: start=%0b data=%h halt=%0b we=%0b addr=%0d wdata=%h busy=%0b, required all 0",
               tx_start, tx_data, core_halt, dbg_we, dbg_addr, dbg_wdata, busy);
    end
    rst = 1'b1;
    m_halted = 1'b0;
    repeat (60) tick();
    checks++;
    if (txq.size() != 1) begin
      errors++;
      $display("FAIL reset_no_tx: %0d bytes total, required 1", txq.size());
    end
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 32; i++) begin
      v = $urandom;
      rf[i] = v;
      m_regs[i] = v;
    end
    test_reset();
    test_halt_timing();
    test_write_halted();
    test_read();
    test_running_errors();
    test_timeout();
    test_random();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
